// File: rtl/lampfpu_exp_seq.sv
// Multi-cycle bfloat16 exp(x): range reduction by 1/ln2, then a quadratic approximation of 2^r.
// LAMP_EXP_EARLY_OUT_EN lets special/big/tiny operands skip straight from CONV to PACK.
module lampfpu_exp_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       doExp_i,
    input  logic       s_op_i,
    input  logic [7:0] e_op_i,
    input  logic [6:0] f_op_i,
    input  logic       isZ_op_i,
    input  logic       isInf_op_i,
    input  logic       isSNAN_op_i,
    input  logic       isQNAN_op_i,
    output logic       s_res_o,
    output logic [7:0] e_res_o,
    output logic [6:0] f_res_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       isOverflow_o,
    output logic       isUnderflow_o,
    output logic       isToRound_o
);
    localparam logic [15:0] INVLN2   = 16'hB8AA;
    localparam logic [15:0] C1       = 16'd43030;
    localparam logic [15:0] C2       = 16'd22506;
    localparam int          FIX_FRAC = 16;

`ifdef LAMP_EXP_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_MUL, S_POLY1, S_POLY2, S_PACK} state_t;
    typedef enum logic [2:0] {K_NORM, K_NAN, K_INF, K_ZERO, K_ONE, K_ONE_RND, K_OVF, K_UNF} kind_t;

    typedef struct packed {
        logic       ovf;
        logic       unf;
        logic       rnd;
        logic [7:0] e;
        logic [6:0] f;
    } res_t;

    // Fixed result for every operand class that bypasses the polynomial.
    function automatic res_t special_res(input kind_t kind);
        res_t r;
        r = '0;
        case (kind)
            K_NAN:     begin r.e = 8'hFF; r.f = 7'h40; end
            K_INF:     r.e = 8'hFF;
            K_ONE:     r.e = 8'd127;
            K_ONE_RND: begin r.e = 8'd127; r.rnd = 1'b1; end
            K_OVF:     begin r.e = 8'hFF; r.ovf = 1'b1; end
            K_UNF:     r.unf = 1'b1;
            default:   r = '0;
        endcase
        return r;
    endfunction

    state_t             state_q;
    kind_t              kind_q;
    logic               s_q, isz_q, isinf_q, isnan_q;
    logic [7:0]         e_q;
    logic [6:0]         f_q;
    logic signed [24:0] x_q;
    logic signed [8:0]  k_q;
    logic [15:0]        r_q;
    logic [16:0]        t_q;

    logic signed [9:0]  eu, neg_eu;
    logic [24:0]        mant, xmag;
    logic signed [24:0] x_d;
    kind_t              kind_d;
    logic signed [41:0] prod;
    logic signed [24:0] y;
    logic [31:0]        c2r;
    logic [16:0]        t_d;
    logic [32:0]        rt;
    logic [17:0]        p_raw;
    logic [16:0]        p_n;
    logic signed [10:0] e_n;
    res_t               res_norm, res_d;

    always_comb begin
        eu     = $signed({2'b00, e_q}) - 10'sd127;
        neg_eu = -eu;
        mant   = 25'({1'b1, f_q}) << (FIX_FRAC - 7);
        xmag   = eu[9] ? (mant >> neg_eu[3:0]) : (mant << eu[2:0]);
        x_d    = s_q ? -$signed(xmag) : $signed(xmag);

        kind_d = K_NORM;
        if (isnan_q)               kind_d = K_NAN;
        else if (isinf_q)          kind_d = s_q ? K_ZERO : K_INF;
        else if (isz_q)            kind_d = K_ONE;
        else if (eu >= 10'sd7)     kind_d = s_q ? K_UNF : K_OVF;
        else if (eu <= -10'sd10)   kind_d = K_ONE_RND;
    end

    // y = x/ln2 in Q8.16; the slice is an arithmetic shift right by 15 (floor).
    always_comb begin
        prod = 42'(x_q) * 42'($signed({1'b0, INVLN2}));
        y    = prod[39:15];
        c2r  = 32'(C2) * 32'(r_q);
        t_d  = 17'(C1) + 17'(c2r[31:16]);
        rt   = 33'(r_q) * 33'(t_q);
    end

    always_comb begin
        p_raw = 18'h10000 + 18'(rt[32:16]);
        p_n   = p_raw[17] ? p_raw[17:1] : p_raw[16:0];
        e_n   = 11'(k_q) + 11'sd127 + 11'(p_raw[17]);

        res_norm = '0;
        if (e_n >= 11'sd255) begin
            res_norm.ovf = 1'b1;
            res_norm.e   = 8'hFF;
        end else if (e_n <= 11'sd0) begin
            res_norm.unf = 1'b1;
        end else begin
            res_norm.e   = e_n[7:0];
            res_norm.f   = p_n[15:9];
            res_norm.rnd = |p_n[8:0];
        end
        res_d = (kind_q == K_NORM) ? res_norm : special_res(kind_q);
    end

    logic unused_bits;
    assign unused_bits = ^{prod[41:40], prod[14:0], c2r[15:0], rt[15:0], p_n[16], neg_eu[9:4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            kind_q        <= K_NORM;
            s_q           <= 1'b0;
            isz_q         <= 1'b0;
            isinf_q       <= 1'b0;
            isnan_q       <= 1'b0;
            e_q           <= '0;
            f_q           <= '0;
            x_q           <= '0;
            k_q           <= '0;
            r_q           <= '0;
            t_q           <= '0;
            s_res_o       <= 1'b0;
            e_res_o       <= '0;
            f_res_o       <= '0;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            isOverflow_o  <= 1'b0;
            isUnderflow_o <= 1'b0;
            isToRound_o   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (doExp_i) begin
                    s_q     <= s_op_i;
                    e_q     <= e_op_i;
                    f_q     <= f_op_i;
                    isz_q   <= isZ_op_i;
                    isinf_q <= isInf_op_i;
                    isnan_q <= isSNAN_op_i | isQNAN_op_i;
                    busy_o  <= 1'b1;
                    state_q <= S_CONV;
                end
                S_CONV: begin
                    x_q     <= x_d;
                    kind_q  <= kind_d;
                    state_q <= S_MUL;
                    if (EARLY_OUT && kind_d != K_NORM) begin
                        {isOverflow_o, isUnderflow_o, isToRound_o, e_res_o, f_res_o} <= special_res(kind_d);
                        s_res_o <= 1'b0;
                        valid_o <= 1'b1;
                        state_q <= S_PACK;
                    end
                end
                S_MUL: begin
                    k_q     <= y[24:16];
                    r_q     <= y[FIX_FRAC-1:0];
                    state_q <= S_POLY1;
                end
                S_POLY1: begin
                    t_q     <= t_d;
                    state_q <= S_POLY2;
                end
                // Outputs load on the edge into PACK so valid_o and the result appear together.
                S_POLY2: begin
                    {isOverflow_o, isUnderflow_o, isToRound_o, e_res_o, f_res_o} <= res_d;
                    s_res_o <= 1'b0;
                    valid_o <= 1'b1;
                    state_q <= S_PACK;
                end
                S_PACK: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lampfpu_exp_seq.sv
// Directed bench for lampfpu_exp_seq: hand-computed exp() results, latency, ignore and reset cases.
`timescale 1ns/1ps
module tb_lampfpu_exp_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       doExp_i = 1'b0;
    logic       s_op_i = 1'b0;
    logic [7:0] e_op_i = '0;
    logic [6:0] f_op_i = '0;
    logic       isZ_op_i = 1'b0, isInf_op_i = 1'b0, isSNAN_op_i = 1'b0, isQNAN_op_i = 1'b0;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o, busy_o, isOverflow_o, isUnderflow_o, isToRound_o;

    int n_checks = 0;
    int n_err = 0;

`ifdef LAMP_EXP_EARLY_OUT_EN
    localparam int SP_LAT = 2;
`else
    localparam int SP_LAT = 5;
`endif

    always #5 clk = ~clk;

    lampfpu_exp_seq dut (
        .clk(clk), .rst(rst), .doExp_i(doExp_i),
        .s_op_i(s_op_i), .e_op_i(e_op_i), .f_op_i(f_op_i),
        .isZ_op_i(isZ_op_i), .isInf_op_i(isInf_op_i),
        .isSNAN_op_i(isSNAN_op_i), .isQNAN_op_i(isQNAN_op_i),
        .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
        .valid_o(valid_o), .busy_o(busy_o),
        .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o), .isToRound_o(isToRound_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        assert (obs >= lo && obs <= hi && !$isunknown(obs)) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h..0x%0h", tag, obs, lo, hi);
        end
    endtask

    // Classify like the unpack stage, drive for one cycle, return #1 after the accepting edge.
    task automatic drive_op(input logic [15:0] op);
        @(negedge clk);
        s_op_i      = op[15];
        e_op_i      = op[14:7];
        f_op_i      = op[6:0];
        isZ_op_i    = (op[14:7] == 8'h00) && (op[6:0] == 7'h00);
        isInf_op_i  = (op[14:7] == 8'hFF) && (op[6:0] == 7'h00);
        isQNAN_op_i = (op[14:7] == 8'hFF) && (op[6:0] != 7'h00) && op[6];
        isSNAN_op_i = (op[14:7] == 8'hFF) && (op[6:0] != 7'h00) && !op[6];
        doExp_i     = 1'b1;
        @(posedge clk);
        #1;
        doExp_i = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [15:0] op, input int exp_lat,
                             input logic [14:0] lo, input logic [14:0] hi,
                             input logic [2:0] exp_flags, input logic [2:0] mask);
        int   lat;
        logic busy1;
        drive_op(op);
        lat   = 0;
        busy1 = busy_o;
        for (int c = 1; c <= 12; c++) begin
            if (valid_o) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, busy1, 1'b1);
        chk_rng({tag, " result"}, {e_res_o, f_res_o}, lo, hi);
        chk({tag, " sign"}, s_res_o, 1'b0);
        chk({tag, " flags"}, {isOverflow_o, isUnderflow_o, isToRound_o} & mask, exp_flags & mask);
        @(posedge clk);
        #1;
        chk({tag, " idle"}, {valid_o, busy_o}, 2'b00);
    endtask

    initial begin
        int       nval, first, cnt;
        logic     b6;
        logic [14:0] ef;

        // reset
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {valid_o, busy_o, s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isToRound_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        // normal path
        run_check("exp(1)",    16'h3F80, 5, {8'h80, 7'h2D}, {8'h80, 7'h2E}, 3'b001, 3'b111);
        run_check("exp(-1)",   16'hBF80, 5, {8'h7D, 7'h3B}, {8'h7D, 7'h3D}, 3'b001, 3'b111);
        run_check("exp(0.5)",  16'h3F00, 5, {8'h7F, 7'h52}, {8'h7F, 7'h54}, 3'b001, 3'b111);
        run_check("exp(2)",    16'h4000, 5, {8'h81, 7'h6B}, {8'h81, 7'h6D}, 3'b001, 3'b111);
        run_check("exp(2^-9)", 16'h3B00, 5, {8'h7E, 7'h7F}, {8'h7F, 7'h01}, 3'b001, 3'b111);
        run_check("exp(100)",  16'h42C8, 5, {8'hFF, 7'h00}, {8'hFF, 7'h00}, 3'b100, 3'b110);
        run_check("exp(-100)", 16'hC2C8, 5, {8'h00, 7'h00}, {8'h00, 7'h00}, 3'b010, 3'b110);

        // special, big and tiny operands
        run_check("exp(+0)",   16'h0000, SP_LAT, {8'h7F, 7'h00}, {8'h7F, 7'h00}, 3'b000, 3'b111);
        run_check("exp(-0)",   16'h8000, SP_LAT, {8'h7F, 7'h00}, {8'h7F, 7'h00}, 3'b000, 3'b111);
        run_check("exp(128)",  16'h4300, SP_LAT, {8'hFF, 7'h00}, {8'hFF, 7'h00}, 3'b100, 3'b110);
        run_check("exp(-128)", 16'hC300, SP_LAT, {8'h00, 7'h00}, {8'h00, 7'h00}, 3'b010, 3'b110);
        run_check("exp(qnan)", 16'h7FC1, SP_LAT, {8'hFF, 7'h40}, {8'hFF, 7'h40}, 3'b000, 3'b111);
        run_check("exp(snan)", 16'h7F81, SP_LAT, {8'hFF, 7'h40}, {8'hFF, 7'h40}, 3'b000, 3'b111);
        run_check("exp(+inf)", 16'h7F80, SP_LAT, {8'hFF, 7'h00}, {8'hFF, 7'h00}, 3'b000, 3'b000);
        run_check("exp(-inf)", 16'hFF80, SP_LAT, {8'h00, 7'h00}, {8'h00, 7'h00}, 3'b000, 3'b000);
        run_check("exp(tiny)", 16'h3A80, SP_LAT, {8'h7F, 7'h00}, {8'h7F, 7'h00}, 3'b001, 3'b001);

        // doExp_i while busy (N+2) and during the valid cycle must both be ignored
        drive_op(16'h3F80);
        @(posedge clk);
        #1;
        s_op_i  = 1'b1;
        e_op_i  = 8'h7F;
        f_op_i  = 7'h00;
        doExp_i = 1'b1;
        @(posedge clk);
        #1;
        doExp_i = 1'b0;
        nval = 0;
        first = 0;
        b6 = 1'b1;
        ef = '0;
        for (int c = 3; c <= 14; c++) begin
            if (c == 6) b6 = busy_o;
            if (valid_o) begin
                nval++;
                if (first == 0) begin
                    first   = c;
                    ef      = {e_res_o, f_res_o};
                    doExp_i = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            doExp_i = 1'b0;
        end
        chk("ignore valid count", nval, 1);
        chk("ignore valid cycle", first, 5);
        chk_rng("ignore result", ef, {8'h80, 7'h2D}, {8'h80, 7'h2E});
        chk("ignore in pack", b6, 1'b0);

        // asynchronous reset mid-operation
        drive_op(16'h3F00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2 rst = 1'b1;
        #1;
        chk("async reset", {valid_o, busy_o, s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isToRound_o}, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (valid_o) cnt++;
        end
        chk("aborted op valid", cnt, 0);
        run_check("after reset", 16'h3F80, 5, {8'h80, 7'h2D}, {8'h80, 7'h2E}, 3'b001, 3'b111);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
